// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//
// Request-side controller that sits in front of a direct-mapped cache lookup
// block (16-bit byte address, 256 lines, 4 words per line, 133-bit line
// {valid, tag[3:0], w0, w1, w2, w3}). One read request is handled at a time:
// the address is presented to the lookup, a hit is answered straight away,
// and a miss fetches the 4-word block from memory, writes the assembled line
// into the cache array and then answers with the requested word.
//
// Address layout: [15:12] tag, [11:4] index, [3:2] word offset, [1:0] ignored.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous, active-low reset
//   req_valid_i      request valid
//   req_ready_o      controller can accept a request (IDLE only)
//   req_addr_i       request byte address
//   resp_valid_o     response valid
//   resp_ready_i     consumer accepts response
//   resp_data_o      returned word
//   resp_hit_o       1 = served from cache, 0 = served after refill
//   lookup_addr_o    address driven to the cache lookup (last latched address)
//   lookup_hit_i     hit from the cache lookup (combinational on lookup_addr_o)
//   lookup_data_i    data word from the cache lookup
//   mem_req_valid_o  block-read request valid
//   mem_req_ready_i  memory accepts the block-read request
//   mem_req_addr_o   block-aligned address {tag, index, 4'b0}
//   mem_rvalid_i     read-data beat valid
//   mem_rdata_i      read-data beat
//   line_we_o        one-cycle cache line write strobe
//   line_index_o     line index to write
//   line_data_o      line to write {1'b1, tag, w0, w1, w2, w3}
//
// Optional feature (macro CACHE_STATS_EN):
//   hit_count_o      saturating count of lookups that hit
//   miss_count_o     saturating count of lookups that missed
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
   parameter int MEM_BEATS = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic [15:0]  req_addr_i,
   output logic         resp_valid_o,
   input  logic         resp_ready_i,
   output logic [31:0]  resp_data_o,
   output logic         resp_hit_o,
   output logic [15:0]  lookup_addr_o,
   input  logic         lookup_hit_i,
   input  logic [31:0]  lookup_data_i,
   output logic         mem_req_valid_o,
   input  logic         mem_req_ready_i,
   output logic [15:0]  mem_req_addr_o,
   input  logic         mem_rvalid_i,
   input  logic [31:0]  mem_rdata_i,
   output logic         line_we_o,
   output logic [7:0]   line_index_o,
   output logic [132:0] line_data_o
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]  hit_count_o,
   output logic [15:0]  miss_count_o
`endif
);

   // The line format and the 2-bit beat counter only work for 4-word blocks.
   generate
      if (MEM_BEATS != 4) begin : g_beats_check
         $error("cache_refill_ctrl: MEM_BEATS must be 4");
      end
   endgenerate

   localparam logic [1:0] LAST_BEAT = 2'(MEM_BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MREQ,
      S_FILL,
      S_WRITE,
      S_RESP
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [15:0]      addr_q;
   logic [1:0]       beat_cnt;
   logic [3:0][31:0] fill_buf;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. LOOKUP and WRITE always last exactly one cycle.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (req_valid_i) next_state = S_LOOKUP;
         S_LOOKUP: next_state = lookup_hit_i ? S_RESP : S_MREQ;
         S_MREQ:   if (mem_req_ready_i) next_state = S_FILL;
         S_FILL:   if (mem_rvalid_i && (beat_cnt == LAST_BEAT)) next_state = S_WRITE;
         S_WRITE:  next_state = S_RESP;
         S_RESP:   if (resp_ready_i) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Output decode. Strobes and the memory/line buses are forced to zero
   // outside their own states so nothing downstream sees stale values.
   always_comb begin
      req_ready_o     = 1'b0;
      resp_valid_o    = 1'b0;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      line_we_o       = 1'b0;
      line_index_o    = '0;
      line_data_o     = '0;
      case (state)
         S_IDLE: req_ready_o = 1'b1;
         S_MREQ: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = {addr_q[15:4], 4'b0000};
         end
         S_WRITE: begin
            line_we_o    = 1'b1;
            line_index_o = addr_q[11:4];
            line_data_o  = {1'b1, addr_q[15:12],
                            fill_buf[0], fill_buf[1], fill_buf[2], fill_buf[3]};
         end
         S_RESP: resp_valid_o = 1'b1;
         default: ;
      endcase
   end

   assign lookup_addr_o = addr_q;

   // Datapath: latched address, beat counter, fill buffer and the response
   // registers. Beats are stored in arrival order (beat k is word k), and the
   // beat matching the requested offset is captured as the response word so
   // RESP needs no extra mux. Beats arriving outside FILL fall through.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_q      <= '0;
         beat_cnt    <= '0;
         fill_buf    <= '0;
         resp_data_o <= '0;
         resp_hit_o  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i) addr_q <= req_addr_i;
            end
            S_LOOKUP: begin
               if (lookup_hit_i) begin
                  resp_data_o <= lookup_data_i;
                  resp_hit_o  <= 1'b1;
               end
            end
            S_MREQ: begin
               if (mem_req_ready_i) beat_cnt <= '0;
            end
            S_FILL: begin
               if (mem_rvalid_i) begin
                  fill_buf[beat_cnt] <= mem_rdata_i;
                  if (beat_cnt == addr_q[3:2]) resp_data_o <= mem_rdata_i;
                  beat_cnt <= beat_cnt + 2'd1;
               end
            end
            S_WRITE: begin
               resp_hit_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   // Every lookup leaves LOOKUP after one cycle, so each LOOKUP cycle bumps
   // exactly one of the two counters; both stick at all-ones.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else if (state == S_LOOKUP) begin
         if (lookup_hit_i) begin
            if (hit_count_o != 16'hFFFF) hit_count_o <= hit_count_o + 16'd1;
         end else begin
            if (miss_count_o != 16'hFFFF) miss_count_o <= miss_count_o + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Self-checking bench for cache_refill_ctrl. The bench provides the cache
// array (lookup + line write) and a memory responder, and keeps a reference
// model of which lines are valid and what they hold. Expected responses,
// line writes and memory requests come from that model and from the address
// rules, transaction by transaction.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;

   logic         clk_i;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [15:0]  req_addr_i;
   logic         resp_valid_o;
   logic         resp_ready_i;
   logic [31:0]  resp_data_o;
   logic         resp_hit_o;
   logic [15:0]  lookup_addr_o;
   logic         lookup_hit_i;
   logic [31:0]  lookup_data_i;
   logic         mem_req_valid_o;
   logic         mem_req_ready_i;
   logic [15:0]  mem_req_addr_o;
   logic         mem_rvalid_i;
   logic [31:0]  mem_rdata_i;
   logic         line_we_o;
   logic [7:0]   line_index_o;
   logic [132:0] line_data_o;
`ifdef CACHE_STATS_EN
   logic [15:0]  hit_count_o;
   logic [15:0]  miss_count_o;
`endif

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   // Cache array seen by the lookup, written by the DUT or by preloads.
   logic [132:0] env_line [256] = '{default: '0};
   logic [132:0] cur_line;
   logic         preload_we;
   logic [7:0]   preload_idx;
   logic [132:0] preload_line;

   // Reference model of the cache contents.
   bit          ref_valid [256];
   logic [3:0]  ref_tag   [256];
   logic [31:0] ref_word  [256][4];

   cache_refill_ctrl dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .resp_valid_o    (resp_valid_o),
      .resp_ready_i    (resp_ready_i),
      .resp_data_o     (resp_data_o),
      .resp_hit_o      (resp_hit_o),
      .lookup_addr_o   (lookup_addr_o),
      .lookup_hit_i    (lookup_hit_i),
      .lookup_data_i   (lookup_data_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rdata_i     (mem_rdata_i),
      .line_we_o       (line_we_o),
      .line_index_o    (line_index_o),
      .line_data_o     (line_data_o)
`ifdef CACHE_STATS_EN
      ,
      .hit_count_o     (hit_count_o),
      .miss_count_o    (miss_count_o)
`endif
   );

   // Free-running clock, active edge is posedge.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Cache lookup: combinational on lookup_addr_o, w0 in the top word.
   always_comb begin
      cur_line     = env_line[lookup_addr_o[11:4]];
      lookup_hit_i = cur_line[132] && (cur_line[131:128] == lookup_addr_o[15:12]);
      case (lookup_addr_o[3:2])
         2'd0:    lookup_data_i = cur_line[127:96];
         2'd1:    lookup_data_i = cur_line[95:64];
         2'd2:    lookup_data_i = cur_line[63:32];
         default: lookup_data_i = cur_line[31:0];
      endcase
   end

   // Cache array write port plus count of line writes.
   always @(posedge clk_i) begin
      if (line_we_o) begin
         env_line[line_index_o] <= line_data_o;
         we_count <= we_count + 1;
      end else if (preload_we) begin
         env_line[preload_idx] <= preload_line;
      end
   end

   // Contents of external memory: fixed pattern for block 5A0, otherwise a
   // value unique to each block and word.
   function automatic logic [31:0] mem_word(input logic [15:0] a, input int k);
      logic [11:0] blk;
      blk = a[15:4];
      if (blk == 12'h5A0) return 32'h11111111 * 32'(k + 1);
      return {8'hC3, 4'(k), blk, 8'h5A};
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [132:0] observed,
                              input logic [132:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reset/idle appearance: everything low except req_ready_o.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_req_ready"}, 133'(req_ready_o), 133'(1));
      checkOutput({tag, "_outputs_zero"},
                  133'({resp_valid_o, resp_data_o, resp_hit_o, lookup_addr_o,
                        mem_req_valid_o, mem_req_addr_o, line_we_o, line_index_o}),
                  133'(0));
      checkOutput({tag, "_line_data_zero"}, line_data_o, 133'(0));
`ifdef CACHE_STATS_EN
      checkOutput({tag, "_hit_count"}, 133'(hit_count_o), 133'(0));
      checkOutput({tag, "_miss_count"}, 133'(miss_count_o), 133'(0));
`endif
   endtask

   task automatic preloadLine(input logic [7:0] idx, input logic [3:0] tag,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
      preload_we   = 1'b1;
      preload_idx  = idx;
      preload_line = {1'b1, tag, w0, w1, w2, w3};
      @(posedge clk_i);
      @(negedge clk_i);
      preload_we     = 1'b0;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
      ref_word[idx][0] = w0;
      ref_word[idx][1] = w1;
      ref_word[idx][2] = w2;
      ref_word[idx][3] = w3;
   endtask

   // One complete request. Called at a negedge with the DUT idle.
   // abort_beat >= 0 pulls reset right after that beat (0-based) is taken.
   task automatic applyStimulus(input logic [15:0] addr, input int mreq_wait,
                                input int resp_wait, input int max_gap,
                                input int abort_beat);
      logic [7:0]   idx;
      logic [3:0]   tag;
      logic [1:0]   off;
      logic         exp_hit;
      logic [31:0]  exp_data;
      logic [132:0] exp_line;
      int           we_before;
      int           gap;

      idx       = addr[11:4];
      tag       = addr[15:12];
      off       = addr[3:2];
      exp_hit   = ref_valid[idx] && (ref_tag[idx] == tag);
      exp_data  = '0;
      we_before = we_count;

      checkOutput("req_ready_idle", 133'(req_ready_o), 133'(1));
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i  = 16'($urandom);
      checkOutput("req_ready_lookup", 133'(req_ready_o), 133'(0));
      checkOutput("lookup_addr", 133'(lookup_addr_o[15:2]), 133'(addr[15:2]));
      checkOutput("resp_valid_lookup", 133'(resp_valid_o), 133'(0));

      if (exp_hit) begin
         exp_hits++;
         exp_data = ref_word[idx][off];
         @(negedge clk_i);
         checkOutput("mem_req_on_hit", 133'(mem_req_valid_o), 133'(0));
      end else begin
         exp_misses++;
         @(negedge clk_i);
         for (int i = 0; i <= mreq_wait; i++) begin
            checkOutput("mem_req_valid", 133'(mem_req_valid_o), 133'(1));
            checkOutput("mem_req_addr", 133'(mem_req_addr_o), 133'({addr[15:4], 4'h0}));
            checkOutput("req_ready_mreq", 133'(req_ready_o), 133'(0));
            if (i < mreq_wait) begin
               mem_rvalid_i = 1'($urandom_range(0, 1));
               mem_rdata_i  = $urandom;
               @(negedge clk_i);
            end
         end
         mem_rvalid_i    = 1'b0;
         mem_req_ready_i = 1'b1;
         @(posedge clk_i);
         @(negedge clk_i);
         mem_req_ready_i = 1'b0;
         for (int k = 0; k < 4; k++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
               @(negedge clk_i);
               checkOutput("line_we_fill_gap", 133'(line_we_o), 133'(0));
               checkOutput("mem_req_fill_gap", 133'(mem_req_valid_o), 133'(0));
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(addr, k);
            @(posedge clk_i);
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (k == abort_beat) begin
               rst_i = 1'b0;
               #1;
               exp_hits   = 0;
               exp_misses = 0;
               checkResetState("reset_mid_fill");
               @(negedge clk_i);
               rst_i = 1'b1;
               checkOutput("no_line_write_after_abort", 133'(we_count - we_before), 133'(0));
               return;
            end
         end
         exp_line = {1'b1, tag, mem_word(addr, 0), mem_word(addr, 1),
                     mem_word(addr, 2), mem_word(addr, 3)};
         checkOutput("line_we", 133'(line_we_o), 133'(1));
         checkOutput("line_index", 133'(line_index_o), 133'(idx));
         checkOutput("line_data", line_data_o, exp_line);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tag;
         for (int k = 0; k < 4; k++) ref_word[idx][k] = mem_word(addr, k);
         exp_data = mem_word(addr, int'(off));
         @(negedge clk_i);
      end

      checkOutput("resp_valid", 133'(resp_valid_o), 133'(1));
      checkOutput("resp_hit", 133'(resp_hit_o), 133'(exp_hit));
      checkOutput("resp_data", 133'(resp_data_o), 133'(exp_data));
      for (int i = 0; i < resp_wait; i++) begin
         @(negedge clk_i);
         checkOutput("resp_valid_stall", 133'(resp_valid_o), 133'(1));
         checkOutput("resp_data_stall", 133'(resp_data_o), 133'(exp_data));
         checkOutput("resp_hit_stall", 133'(resp_hit_o), 133'(exp_hit));
         checkOutput("req_ready_stall", 133'(req_ready_o), 133'(0));
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      resp_ready_i = 1'b0;
      checkOutput("resp_valid_done", 133'(resp_valid_o), 133'(0));
      checkOutput("req_ready_done", 133'(req_ready_o), 133'(1));
      checkOutput("line_write_count", 133'(we_count - we_before), 133'(exp_hit ? 0 : 1));
`ifdef CACHE_STATS_EN
      checkOutput("hit_count", 133'(hit_count_o), 133'(exp_hits));
      checkOutput("miss_count", 133'(miss_count_o), 133'(exp_misses));
`endif
   endtask

   initial begin
      logic [3:0]  tags [2];
      logic [7:0]  idxs [4];
      logic [15:0] raddr;

      tags[0] = 4'h3;  tags[1] = 4'h5;
      idxs[0] = 8'h12; idxs[1] = 8'hA0; idxs[2] = 8'h33; idxs[3] = 8'hF7;
      for (int i = 0; i < 256; i++) begin
         ref_valid[i] = 1'b0;
         ref_tag[i]   = '0;
         for (int k = 0; k < 4; k++) ref_word[i][k] = '0;
      end

      rst_i           = 1'b0;
      req_valid_i     = 1'b0;
      req_addr_i      = '0;
      resp_ready_i    = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_rvalid_i    = 1'b0;
      mem_rdata_i     = '0;
      preload_we      = 1'b0;
      preload_idx     = '0;
      preload_line    = '0;

      repeat (3) @(negedge clk_i);
      checkResetState("reset");
      rst_i = 1'b1;
      @(negedge clk_i);

      $display("[TB] directed hit on preloaded line");
      preloadLine(8'h12, 4'h3, 32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
      applyStimulus(16'h312C, 0, 0, 0, -1);

      $display("[TB] directed miss refill then re-read");
      applyStimulus(16'h5A08, 0, 0, 0, -1);
      applyStimulus(16'h5A08, 0, 0, 0, -1);

      $display("[TB] backpressure on memory request, beats and response");
      applyStimulus(16'h7B34, 5, 3, 3, -1);

      $display("[TB] reset in the middle of a fill");
      applyStimulus(16'h9C10, 1, 0, 2, 1);
      applyStimulus(16'h9C10, 0, 1, 1, -1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) begin
         raddr = {tags[$urandom_range(0, 1)], idxs[$urandom_range(0, 3)], 4'($urandom)};
         applyStimulus(raddr, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 2), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
